// File: rtl/fx3_packet_streamer.sv
// FX3 GPIF-II read-side packet sequencer.
// Cuts the sample stream into fixed-length packets and adds enable gating,
// an inter-packet gap, abort detection and a packet counter.
module fx3_packet_streamer #(
  parameter int unsigned PACKET_WORDS = 8192,
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned PKTCNT_W     = 16
) (
  input  logic                           inclk,
  input  logic                           nReset,
  input  logic                           enable,
  input  logic                           readData,
  input  logic                           fifoReady,
  output logic                           fx3isReading,
  output logic [$clog2(PACKET_WORDS)-1:0] wordCount,
  output logic                           packetDone,
  output logic [PKTCNT_W-1:0]            packetCount,
  output logic                           aborted
);

  localparam int unsigned CNT_W    = $clog2(PACKET_WORDS);
  localparam int unsigned GAP_W    = 8;
  localparam bit          HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PACKET_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    SEND     = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t               state, stateNext;
  logic                 readDataQ, fifoReadyQ;
  logic [GAP_W-1:0]     gapCnt, gapCntNext;
  logic [CNT_W-1:0]     wordCountNext;
  logic                 packetDoneNext;
  logic [PKTCNT_W-1:0]  packetCountNext;
  logic                 abortedNext;
  logic                 lastWord;

  // GPIF request and buffer level are registered once; the FSM sees only these copies
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      readDataQ  <= 1'b0;
      fifoReadyQ <= 1'b0;
    end else begin
      readDataQ  <= readData;
      fifoReadyQ <= fifoReady;
    end
  end

  // State and output registers
  always_ff @(posedge inclk or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      gapCnt      <= '0;
      wordCount   <= '0;
      packetDone  <= 1'b0;
      packetCount <= '0;
      aborted     <= 1'b0;
    end else begin
      state       <= stateNext;
      gapCnt      <= gapCntNext;
      wordCount   <= wordCountNext;
      packetDone  <= packetDoneNext;
      packetCount <= packetCountNext;
      aborted     <= abortedNext;
    end
  end

  assign lastWord = (wordCount == LAST_WORD);

  // Next-state and next-output decode; completion on the last word beats abort
  always_comb begin
    stateNext       = state;
    gapCntNext      = '0;
    wordCountNext   = '0;
    packetDoneNext  = 1'b0;
    packetCountNext = packetCount;
    abortedNext     = aborted;
    case (state)
      IDLE: begin
        abortedNext = 1'b0;
        if (enable) stateNext = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (!enable)                      stateNext = IDLE;
        else if (readDataQ && fifoReadyQ) stateNext = SEND;
      end
      SEND: begin
        if (lastWord) begin
          packetDoneNext  = 1'b1;
          packetCountNext = packetCount + PKTCNT_W'(1);
          stateNext       = HAS_GAP ? GAP : WAIT_REQ;
        end else if (!readDataQ) begin
          abortedNext = 1'b1;
          stateNext   = WAIT_REQ;
        end else begin
          wordCountNext = wordCount + CNT_W'(1);
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST) stateNext  = WAIT_REQ;
        else                    gapCntNext = gapCnt + GAP_W'(1);
      end
      default: stateNext = IDLE;
    endcase
  end

  // A word moves on every SEND cycle
  assign fx3isReading = (state == SEND);

endmodule

// File: tb/tb_fx3_packet_streamer.sv
// Directed self-checking bench for fx3_packet_streamer (16-word packets, 3-cycle gap, 4-bit counter).
module tb_fx3_packet_streamer;

  localparam int unsigned PW  = 16;
  localparam int unsigned GAP = 3;
  localparam int unsigned PCW = 4;

  logic           inclk = 1'b0;
  logic           nReset;
  logic           enable, readData, fifoReady;
  logic           fx3isReading;
  logic [3:0]     wordCount;
  logic           packetDone;
  logic [PCW-1:0] packetCount;
  logic           aborted;

  int total = 0;
  int bad   = 0;

  fx3_packet_streamer #(.PACKET_WORDS(PW), .GAP_CYCLES(GAP), .PKTCNT_W(PCW)) dut (
    .inclk(inclk), .nReset(nReset), .enable(enable), .readData(readData),
    .fifoReady(fifoReady), .fx3isReading(fx3isReading), .wordCount(wordCount),
    .packetDone(packetDone), .packetCount(packetCount), .aborted(aborted)
  );

  always #5 inclk = ~inclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Step until a word is being transferred; report how many cycles that took
  task automatic waitSend(input string tag, input int expCyc);
    int n = 0;
    while (!fx3isReading && n < 60) begin
      @(negedge inclk);
      n++;
    end
    check(tag, n, expCyc);
  endtask

  // Called at the word-0 cycle; checks all words then the completion cycle
  task automatic checkPacket(input int expCnt, input int enDropAt);
    for (int i = 0; i < PW; i++) begin
      check("pkt_reading", 32'(fx3isReading), 1);
      check("pkt_word", 32'(wordCount), i);
      if (i == enDropAt) enable = 1'b0;
      @(negedge inclk);
    end
    check("pkt_done", 32'(packetDone), 1);
    check("pkt_count", 32'(packetCount), expCnt);
    check("pkt_idle_after", 32'(fx3isReading), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; enable = 1'b0; readData = 1'b0; fifoReady = 1'b0;
    repeat (2) @(negedge inclk);
    nReset = 1'b1;
    @(negedge inclk);
    check("rst_reading", 32'(fx3isReading), 0);
    check("rst_word", 32'(wordCount), 0);
    check("rst_done", 32'(packetDone), 0);
    check("rst_count", 32'(packetCount), 0);
    check("rst_aborted", 32'(aborted), 0);

    // 1: continuous request, two packets with 3 gap + 1 wait cycles between
    enable = 1'b1; fifoReady = 1'b1; readData = 1'b1;
    @(negedge inclk);
    waitSend("t1_latency", 1);
    checkPacket(1, -1);
    check("t1_aborted", 32'(aborted), 0);
    @(negedge inclk);
    check("t1_done_width", 32'(packetDone), 0);
    waitSend("t1_gap", 3);
    checkPacket(2, -1);

    // 2: readData drops during word 5, word 6 still moves, then abort
    waitSend("t2_gap", 4);
    for (int i = 0; i <= 6; i++) begin
      check("t2_word", 32'(wordCount), i);
      check("t2_reading", 32'(fx3isReading), 1);
      if (i == 5) readData = 1'b0;
      @(negedge inclk);
    end
    check("t2_left_send", 32'(fx3isReading), 0);
    check("t2_aborted", 32'(aborted), 1);
    check("t2_no_done", 32'(packetDone), 0);
    check("t2_count_held", 32'(packetCount), 2);
    check("t2_word_zero", 32'(wordCount), 0);
    readData = 1'b1;
    waitSend("t2_restart", 2);
    checkPacket(3, -1);
    check("t2_aborted_sticky", 32'(aborted), 1);

    // 3: buffer not ready blocks transfers despite request
    fifoReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge inclk);
      check("t3_blocked", 32'(fx3isReading), 0);
    end
    fifoReady = 1'b1;
    waitSend("t3_latency", 2);
    checkPacket(4, -1);

    // 4: enable drops at word 8; packet finishes, then FSM parks in IDLE
    waitSend("t4_gap", 4);
    checkPacket(5, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge inclk);
      check("t4_parked", 32'(fx3isReading), 0);
    end
    check("t4_aborted_clr", 32'(aborted), 0);
    check("t4_count", 32'(packetCount), 5);

    // 5: packets 6..17, counter wraps 15 -> 0
    enable = 1'b1;
    waitSend("t5_start", 2);
    for (int n = 6; n <= 17; n++) begin
      checkPacket(n % 16, -1);
      waitSend("t5_gap", 4);
    end

    // 6: asynchronous reset at word 10
    for (int i = 0; i < 10; i++) @(negedge inclk);
    check("t6_pre_word", 32'(wordCount), 10);
    #2 nReset = 1'b0;
    #1;
    check("t6_rst_reading", 32'(fx3isReading), 0);
    check("t6_rst_word", 32'(wordCount), 0);
    check("t6_rst_count", 32'(packetCount), 0);
    check("t6_rst_done", 32'(packetDone), 0);
    check("t6_rst_aborted", 32'(aborted), 0);
    repeat (2) @(negedge inclk);
    nReset = 1'b1;
    @(negedge inclk);
    check("t6_resume_wait", 32'(fx3isReading), 0);
    waitSend("t6_resume", 1);
    checkPacket(1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
